// File: rtl/store_display_renderer.sv
// Renders the 32x32-bit store as a dot/dash raster behind the VGA timing generator.
// Latency: pixel_on, hsync_out, vsync_out and sof_out are all registered one cycle after their inputs.
// Backpressure: one store word is fetched per row during blanking; a fetch not acked by x==0 is aborted as an underrun.
// Ports: clk/reset_n (async active-low); x, y, can_draw, start_of_frame, hsync, vsync from the timing generator;
//        mem_req/mem_addr/mem_ack/mem_data shared store read port; pixel_on and delayed syncs out;
//        underrun pulse and saturating underrun_count (cleared by start_of_frame).
module store_display_renderer #(
  parameter int H_VISIBLE   = 800,
  parameter int V_TOTAL     = 628,
  parameter int X0          = 144,
  parameter int Y0          = 44,
  parameter int CELL_W_LOG2 = 4,
  parameter int CELL_H_LOG2 = 4,
  parameter int LINE_H      = 12,
  parameter int DOT_W       = 4,
  parameter int DASH_GAP    = 4,
  parameter int FETCH_X     = 800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        can_draw,
  input  logic        start_of_frame,
  input  logic        hsync,
  input  logic        vsync,
  output logic        mem_req,
  output logic [4:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        pixel_on,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        sof_out,
  output logic        underrun,
  output logic [7:0]  underrun_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam int WIN_W = 32 << CELL_W_LOG2;
  localparam int WIN_H = 32 << CELL_H_LOG2;
  localparam logic signed [11:0] WIN_W_S  = 12'(WIN_W);
  localparam logic signed [11:0] WIN_H_S  = 12'(WIN_H);
  localparam logic signed [11:0] X0_S     = 12'(X0);
  localparam logic signed [11:0] Y0_S     = 12'(Y0);
  localparam logic [CELL_W_LOG2-1:0] DASH_LEN = CELL_W_LOG2'((1 << CELL_W_LOG2) - DASH_GAP);
  localparam logic [CELL_W_LOG2-1:0] DOT_LEN  = CELL_W_LOG2'(DOT_W);
  localparam logic [CELL_H_LOG2-1:0] LIT_H    = CELL_H_LOG2'(LINE_H);

  logic [0:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic        line_valid_q, line_valid_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  count_q, count_d;
  logic        pixel_q, hs_q, vs_q, sof_q;

  // Fetch target: the line after the current one, wrapping at frame end.
  logic [10:0] tl, tl_off;
  logic        tl_in_win, at_fetch, abort;
  logic [4:0]  row;

  always_comb begin
    tl        = (y == 11'(V_TOTAL - 1)) ? 11'd0 : y + 11'd1;
    tl_in_win = (tl >= 11'(Y0)) && (tl < 11'(Y0 + WIN_H));
    tl_off    = tl - 11'(Y0);
    row       = 5'(tl_off >> CELL_H_LOG2);
    at_fetch  = (x == 11'(FETCH_X));
    // The ack takes priority over the line-wrap deadline.
    abort     = (state_q == S_REQ) && !mem_ack && (x == 11'd0);
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_valid_d = line_valid_q;
    word_buf_d   = word_buf_q;
    underrun_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (at_fetch) begin
          if (tl_in_win) begin
            mem_addr_d = row;
            mem_req_d  = 1'b1;
            state_d    = S_REQ;
          end else begin
            line_valid_d = 1'b0;
          end
        end
      end
      default: begin
        if (mem_ack) begin
          word_buf_d   = mem_data;
          line_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = S_IDLE;
        end else if (abort) begin
          mem_req_d    = 1'b0;
          line_valid_d = 1'b0;
          underrun_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end
    endcase

    // Frame start restarts the count, but an abort in that same cycle still counts.
    if (start_of_frame)
      count_d = abort ? 8'd1 : 8'd0;
    else if (abort && count_q != 8'hFF)
      count_d = count_q + 8'd1;
    else
      count_d = count_q;
  end

  // Signed offsets so positions left of / above the window never wrap into it.
  logic signed [11:0] cx, cy;
  logic [4:0]             col;
  logic [CELL_W_LOG2-1:0] px;
  logic [CELL_H_LOG2-1:0] py;
  logic                   in_win, lit;

  always_comb begin
    cx     = signed'({1'b0, x}) - X0_S;
    cy     = signed'({1'b0, y}) - Y0_S;
    col    = 5'(cx >> CELL_W_LOG2);
    px     = cx[CELL_W_LOG2-1:0];
    py     = cy[CELL_H_LOG2-1:0];
    in_win = (cx >= 12'sd0) && (cx < WIN_W_S) && (cy >= 12'sd0) && (cy < WIN_H_S);
    lit    = can_draw && line_valid_q && in_win && (py < LIT_H) &&
             (word_buf_q[col] ? (px < DASH_LEN) : (px < DOT_LEN));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 5'd0;
      line_valid_q <= 1'b0;
      word_buf_q   <= 32'd0;
      underrun_q   <= 1'b0;
      count_q      <= 8'd0;
      pixel_q      <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      word_buf_q   <= word_buf_d;
      underrun_q   <= underrun_d;
      count_q      <= count_d;
      pixel_q      <= lit;
      hs_q         <= hsync;
      vs_q         <= vsync;
      sof_q        <= start_of_frame;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign pixel_on       = pixel_q;
  assign hsync_out      = hs_q;
  assign vsync_out      = vs_q;
  assign sof_out        = sof_q;
  assign underrun       = underrun_q;
  assign underrun_count = count_q;

endmodule
